zregfile: RTL
=============

Name: zregfile

Overview:
Parametrised successor to the 4x8 register block. A clocked general-purpose register file with one synchronous write port and two combinational read ports. It adds write-first bypass, an optional hardwired-zero R0, and a per-register pending-write scoreboard that the zephyr control path uses for hazard detection. It sits between the decoder and the ALU.

Parameters:
DATA_W, 8, register width in bits
DEPTH, 4, number of registers (power of two, minimum 2)
ADDR_W, $clog2(DEPTH), register select width
ZERO_REG, 0, when 1 R0 reads as zero and ignores writes and reserves

Ports:
CLK  input  1  clock, all state updates on the rising edge
RST_N  input  1  asynchronous active-low reset
WE  input  1  write enable
WADDR  input  ADDR_W  write register select
WDATA  input  DATA_W  write data
RADDR_A  input  ADDR_W  read port A select
RDATA_A  output  DATA_W  read port A data
RADDR_B  input  ADDR_W  read port B select
RDATA_B  output  DATA_W  read port B data
RSV  input  1  reserve: mark RSV_ADDR as pending write
RSV_ADDR  input  ADDR_W  register to reserve
BUSY_A  output  1  pending bit of RADDR_A
BUSY_B  output  1  pending bit of RADDR_B
ANY_BUSY  output  1  OR of all pending bits

Behaviour:
- Reset (RST_N low, asynchronous): all registers become 0; all pending bits become 0. RDATA_A and RDATA_B then read 0, and BUSY_A, BUSY_B and ANY_BUSY are 0. Reset asserted mid-operation discards any write or reserve in that cycle. Release is sampled on the next rising CLK.
- Write: on a rising CLK with WE=1, reg[WADDR] <= WDATA. Latency is 1 cycle to storage.
- Read: RDATA_x = reg[RADDR_x], combinational.
- Write-first bypass: if WE=1 and WADDR==RADDR_x in the same cycle, RDATA_x = WDATA. Bypass applies independently to each port, and both ports may bypass at once.
- ZERO_REG=1: a read of address 0 returns 0 regardless of bypass. A write to address 0 is dropped. A reserve of address 0 is dropped, so the R0 pending bit is always 0.
- Scoreboard: a pending[DEPTH] vector, updated on the rising CLK.
  - RSV=1 sets pending[RSV_ADDR].
  - WE=1 clears pending[WADDR].
  - Simultaneous RSV and WE to the same address: pending ends set, because the reserve belongs to a newer producer. The data write still happens.
  - Simultaneous RSV and WE to different addresses: both take effect.
  - RSV to an already-pending register keeps it set; there is no counting.
  - WE to a non-pending register writes data; pending stays 0.
- BUSY_x = pending[RADDR_x] from registered state, with no bypass of the current-cycle RSV/WE. ANY_BUSY = |pending.
- Out-of-range addresses cannot occur because DEPTH is a power of two.
- State machine: none beyond the per-register pending flag, which is a 2-state FREE/PENDING register. Transitions:
  - FREE to PENDING on RSV.
  - PENDING to FREE on WE without same-address RSV.
  - Reset forces FREE.

Decomposition:
- Package zregfile_pkg holds:
  - default DATA_W/DEPTH constants
  - a function computing the bypass/zero read mux, shared by ports A and B
- Sub-module zregfile_scoreboard holds:
  - the pending vector
  - RSV/WE priority logic
  - BUSY_A/BUSY_B/ANY_BUSY generation
- The top level instantiates the data array and the scoreboard.

Test Plan:
- Reset and fill: hold RST_N=0, then release. Write 0xAA, 0xCC, 0xF0, 0x0F to R0..R3 on successive edges, then read all four on A and in reverse on B. Required: A returns AA, CC, F0, 0F; B returns 0F, F0, CC, AA; all outputs are 0 before the first write.
- Bypass: R1=0xCC stored. Drive WE=1, WADDR=1, WDATA=0x55, with RADDR_A=RADDR_B=1. Required: both ports show 0x55 in the same cycle before the edge, and after the edge reg[1]=0x55.
- Scoreboard: RSV R2, then RADDR_A=2. Required: BUSY_A=1 and ANY_BUSY=1 next cycle. Then WE R2=0x33. Required: BUSY_A=0 and ANY_BUSY=0 after the edge, RDATA_A=0x33.
- Simultaneous events: R3 pending. Drive RSV R3 with WE R3=0x77 on the same edge. Required: reg[3]=0x77 and BUSY stays 1. Next, RSV R1 with WE R3 on the same edge. Required: R1 busy, R3 free.
- ZERO_REG=1 instance: write 0xFF to R0 and RSV R0. Required: RDATA_A(R0)=0 (including during the write cycle), BUSY_A=0, ANY_BUSY=0.
- Reset mid-operation: R0..R3 loaded and R1 pending. Pulse RST_N low between edges with WE=1 active. Required: all reads 0 and all BUSY 0 immediately (asynchronously); the in-flight write is lost. Also run DATA_W=16, DEPTH=8 with a walking-ones pattern across all 8 registers and check readback.

Source files
------------

// File: rtl/zregfile_pkg.sv
// Shared constants and the read-port mux used by both read ports of zregfile.
package zregfile_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 4;

    // Widest register the read mux can carry; instances must keep DATA_W <= MUX_W.
    localparam int MUX_W = 64;

    // Per-register pending flag encoding.
    localparam logic [0:0] PEND_FREE = 1'b0;
    localparam logic [0:0] PEND_SET  = 1'b1;

    // Hardwired zero wins over bypass, bypass wins over stored data.
    function automatic logic [MUX_W-1:0] read_mux(
        input logic [MUX_W-1:0] stored,
        input logic [MUX_W-1:0] wdata,
        input logic             bypass,
        input logic             force_zero
    );
        logic [MUX_W-1:0] r;
        if (force_zero) begin
            r = '0;
        end else if (bypass) begin
            r = wdata;
        end else begin
            r = stored;
        end
        return r;
    endfunction

endpackage

// File: rtl/zregfile_scoreboard.sv
// Pending-write scoreboard: one FREE/PENDING flag per register plus busy lookups.
module zregfile_scoreboard
    import zregfile_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              rsv,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic              busy_a,
    output logic              busy_b,
    output logic              any_busy,
    output logic [DEPTH-1:0]  pending
);

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    // Reserve is applied after the write clear: a same-address reserve comes
    // from a newer producer and must survive the retiring write.
    always_comb begin
        pend_d = pend_q;
        if (we) begin
            pend_d[waddr] = PEND_FREE;
        end
        if (rsv) begin
            pend_d[rsv_addr] = PEND_SET;
        end
        if (ZERO_REG != 0) begin
            pend_d[0] = PEND_FREE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign busy_a   = pend_q[raddr_a];
    assign busy_b   = pend_q[raddr_b];
    assign any_busy = |pend_q;
    assign pending  = pend_q;

endmodule

// File: rtl/zregfile.sv
// Register file: one synchronous write port, two combinational write-first read
// ports, optional hardwired-zero R0 and a pending-write scoreboard.
module zregfile
    import zregfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              rsv,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              busy_a,
    output logic              busy_b,
    output logic              any_busy,
    output logic [DEPTH-1:0]  pending
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_en;
    logic              byp_a;
    logic              byp_b;
    logic              zero_a;
    logic              zero_b;

    assign wr_en = we && !((ZERO_REG != 0) && (waddr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[waddr] <= wdata;
        end
    end

    // Bypass is gated by reset so the in-flight write never shows while held in reset.
    assign byp_a  = rst_n && we && (waddr == raddr_a);
    assign byp_b  = rst_n && we && (waddr == raddr_b);
    assign zero_a = (ZERO_REG != 0) && (raddr_a == '0);
    assign zero_b = (ZERO_REG != 0) && (raddr_b == '0);

    assign rdata_a = DATA_W'(read_mux(MUX_W'(mem[raddr_a]), MUX_W'(wdata), byp_a, zero_a));
    assign rdata_b = DATA_W'(read_mux(MUX_W'(mem[raddr_b]), MUX_W'(wdata), byp_b, zero_b));

    zregfile_scoreboard #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .waddr    (waddr),
        .rsv      (rsv),
        .rsv_addr (rsv_addr),
        .raddr_a  (raddr_a),
        .raddr_b  (raddr_b),
        .busy_a   (busy_a),
        .busy_b   (busy_b),
        .any_busy (any_busy),
        .pending  (pending)
    );

endmodule
